// File: rtl/twiddle_pkg.sv
// Shared types and helpers for the twiddle-factor generator:
// quadrant encoding, pipeline stage tag, and table quantisation.
package twiddle_pkg;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quad_e;

  typedef struct packed {
    quad_e q;
    logic  inv;
    logic  last;
    logic  valid;
  } stage_t;

  // Round half away from zero, then clamp symmetric so -2^(K-1) never appears.
  function automatic int quantise(input real x, input int max_val);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    if (v > max_val) begin
      v = max_val;
    end else if (v < -max_val) begin
      v = -max_val;
    end
    return v;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine table (N/4+1 entries), two registered read ports.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int N = 4096,
  parameter int K = 16
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [$clog2(N)-2:0]  i_addr_a,
  input  logic [$clog2(N)-2:0]  i_addr_b,
  output logic [K-1:0]          o_rd_a,
  output logic [K-1:0]          o_rd_b
);

  localparam int Q   = N / 4;
  localparam int MAX = 2 ** (K - 1) - 1;

  logic [K-1:0] w_tab [0:Q];

  genvar gi;
  generate
    for (gi = 0; gi <= Q; gi++) begin : g_tab
      assign w_tab[gi] = K'(quantise(real'(MAX) * $cos(2.0 * PI * real'(gi) / real'(N)), MAX));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rd_a <= w_tab[i_addr_a];
      o_rd_b <= w_tab[i_addr_b];
    end
  end

endmodule

// File: rtl/twiddle_stream_gen.sv
// Full-circle twiddle source: random-access requests or per-stage DIF streaming,
// folded from a quarter-wave table through a 3-stage stallable pipeline.
module twiddle_stream_gen
  import twiddle_pkg::*;
#(
  parameter int N     = 4096,
  parameter int K     = 16,
  parameter int LOG_N = $clog2(N),
  parameter int STG_W = $clog2(LOG_N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LOG_N-1:0]    req_idx,
  input  logic                inv,
  input  logic                seq_start,
  input  logic [STG_W-1:0]    seq_stage,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [K-1:0] W_re,
  output logic signed [K-1:0] W_im,
  output logic                out_last
);

  localparam int Q    = N / 4;
  localparam int HALF = N / 2;
  localparam int AW   = LOG_N - 1;

  typedef enum logic {ST_IDLE, ST_RUN} seq_state_e;

  seq_state_e          r_state, w_state_next;
  logic [STG_W-1:0]    r_seq_s;
  logic                r_seq_inv;
  logic [LOG_N-2:0]    r_j;
  stage_t              r_s1, r_s2;
  logic [AW-1:0]       r_addr_a, r_addr_b;
  logic                r_out_valid, r_out_last;
  logic signed [K-1:0] r_re, r_im;

  logic                w_en, w_seq_go, w_seq_issue, w_seq_last, w_req_fire, w_issue_valid;
  logic                w_issue_inv;
  logic [STG_W-1:0]    w_stage_clamped;
  logic [LOG_N-1:0]    w_span, w_kj, w_k;
  logic [LOG_N-3:0]    w_r;
  quad_e               w_q;
  logic signed [K-1:0] w_c_r, w_c_qr, w_re, w_im;

  assign w_en        = !r_out_valid || out_ready;
  assign w_seq_go    = (r_state == ST_IDLE) && w_en && seq_start;
  assign w_seq_issue = (r_state == ST_RUN) && w_en;
  assign w_seq_last  = (r_j == (LOG_N-1)'(HALF - 1));
  assign req_ready   = w_en && (r_state == ST_IDLE) && !seq_start;
  assign w_req_fire  = req_valid && req_ready;
  assign busy        = (r_state == ST_RUN);

  // Out-of-range stages collapse onto the last stage, whose indices are all zero.
  assign w_stage_clamped = ({1'b0, seq_stage} >= (STG_W+1)'(LOG_N)) ? STG_W'(LOG_N - 1) : seq_stage;
  assign w_span          = LOG_N'(HALF) >> r_seq_s;
  assign w_kj            = ({1'b0, r_j} & (w_span - LOG_N'(1))) << r_seq_s;

  assign w_k           = w_seq_issue ? w_kj : req_idx;
  assign w_issue_inv   = w_seq_issue ? r_seq_inv : inv;
  assign w_issue_valid = w_seq_issue || w_req_fire;
  assign w_r           = w_k[LOG_N-3:0];
  assign w_q           = quad_e'(w_k[LOG_N-1:LOG_N-2]);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_seq_go) w_state_next = ST_RUN;
      ST_RUN:  if (w_seq_issue && w_seq_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_seq_s   <= '0;
      r_seq_inv <= 1'b0;
      r_j       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_seq_go) begin
        r_seq_s   <= w_stage_clamped;
        r_seq_inv <= inv;
        r_j       <= '0;
      end else if (w_seq_issue) begin
        r_j <= r_j + (LOG_N-1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else if (w_en) begin
      r_s1     <= '{q: w_q, inv: w_issue_inv, last: w_seq_issue && w_seq_last, valid: w_issue_valid};
      r_addr_a <= {1'b0, w_r};
      r_addr_b <= AW'(Q) - {1'b0, w_r};
      r_s2     <= r_s1;
    end
  end

  twiddle_qrom #(.N(N), .K(K)) u_qrom (
    .clk      (clk),
    .i_en     (w_en),
    .i_addr_a (r_addr_a),
    .i_addr_b (r_addr_b),
    .o_rd_a   (w_c_r),
    .o_rd_b   (w_c_qr)
  );

  // Port A holds C[r], port B holds C[Q-r]; each quadrant picks a swap and signs.
  always_comb begin
    w_re = '0;
    w_im = '0;
    case (r_s2.q)
      QUAD_0: begin w_re = w_c_r;   w_im = -w_c_qr; end
      QUAD_1: begin w_re = -w_c_qr; w_im = -w_c_r;  end
      QUAD_2: begin w_re = -w_c_r;  w_im = w_c_qr;  end
      QUAD_3: begin w_re = w_c_qr;  w_im = w_c_r;   end
    endcase
    if (r_s2.inv) w_im = -w_im;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2.valid;
      r_out_last  <= r_s2.valid && r_s2.last;
      r_re        <= r_s2.valid ? w_re : '0;
      r_im        <= r_s2.valid ? w_im : '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign W_re      = r_re;
  assign W_im      = r_im;

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Directed bench for twiddle_stream_gen (N=16): scoreboard against a trig model
// plus literal expectations for latency, folding, sequencing, stall and reset.
module tb_twiddle_stream_gen;

  localparam int N     = 16;
  localparam int K     = 16;
  localparam int LOG_N = 4;
  localparam int STG_W = 2;
  localparam int MAX   = 32767;
  localparam real TB_PI = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [LOG_N-1:0]    req_idx;
  logic                inv;
  logic                seq_start;
  logic [STG_W-1:0]    seq_stage;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic signed [K-1:0] W_re;
  logic signed [K-1:0] W_im;
  logic                out_last;

  twiddle_stream_gen #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .inv       (inv),
    .seq_start (seq_start),
    .seq_stage (seq_stage),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W_re      (W_re),
    .W_im      (W_im),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int k;
    bit inv;
    bit last;
  } exp_t;

  exp_t q_exp[$];
  exp_t mon_e;

  int lit_k[5]  = '{0, 2, 4, 8, 12};
  int lit_re[5] = '{32767, 23170, 0, -32767, 0};
  int lit_im[5] = '{0, -23170, -32767, 0, 32767};
  int b2b_k[10] = '{1, 3, 5, 7, 9, 11, 13, 15, 6, 10};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // W = exp(-j2pi k/N) forward, conjugate for inverse.
  function automatic int model_re(input int k);
    return rnd(real'(MAX) * $cos(2.0 * TB_PI * real'(k) / real'(N)));
  endfunction

  function automatic int model_im(input int k, input bit iv);
    int s;
    s = rnd(real'(MAX) * $sin(2.0 * TB_PI * real'(k) / real'(N)));
    return iv ? s : -s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every valid cycle is compared with the queue head; pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got re=%0d im=%0d, expected no output", W_re, W_im);
      end else begin
        mon_e = q_exp[0];
        check("sb_re", int'(W_re), model_re(mon_e.k));
        check("sb_im", int'(W_im), model_im(mon_e.k, mon_e.inv));
        check("sb_last", int'(out_last), int'(mon_e.last));
        if (out_ready) begin
          void'(q_exp.pop_front());
          $display("[TB] out k=%0d inv=%0d re=%0d im=%0d last=%0d", mon_e.k, mon_e.inv, W_re, W_im, out_last);
        end
      end
    end
  end

  task automatic send_req(input int k, input bit iv, output int acc_cyc);
    bit accepted;
    int guard;
    accepted = 0;
    guard    = 0;
    acc_cyc  = -1;
    req_valid = 1'b1;
    req_idx   = LOG_N'(k);
    inv       = iv;
    while (!accepted && guard < 50) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
        q_exp.push_back('{k: k, inv: iv, last: 1'b0});
      end
      @(posedge clk);
      #1;
      guard++;
    end
    req_valid = 1'b0;
    if (!accepted) check("req_accept_timeout", 0, 1);
  endtask

  task automatic start_seq(input int s, input bit iv, input bit push);
    int sc;
    int span;
    seq_start = 1'b1;
    seq_stage = STG_W'(s);
    inv       = iv;
    @(negedge clk);
    if (push) begin
      sc   = (s >= LOG_N) ? LOG_N - 1 : s;
      span = N >> (sc + 1);
      for (int j = 0; j < N / 2; j++) begin
        q_exp.push_back('{k: (j % span) << sc, inv: iv, last: (j == N / 2 - 1)});
      end
    end
    @(posedge clk);
    #1;
    seq_start = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q_exp.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", q_exp.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev;
    int busy_cnt;
    bit got;

    rst = 1'b1; req_valid = 1'b0; req_idx = '0; inv = 1'b0;
    seq_start = 1'b0; seq_stage = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_w_re", int'(W_re), 0);
    check("rst_w_im", int'(W_im), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single requests: latency and literal factor values, forward then inverse.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 5; i++) begin
        send_req(lit_k[i], p[0], acc);
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
          @(negedge clk);
          if (out_valid) got = 1;
        end
        check("latency_seen", int'(got), 1);
        if (got) begin
          check("latency_cycles", cyc - acc, 3);
          check("lit_re", int'(W_re), lit_re[i]);
          check("lit_im", int'(W_im), (p == 1) ? -lit_im[i] : lit_im[i]);
        end
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    // Back-to-back requests: one accept per cycle.
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      send_req(b2b_k[i], i[0], acc);
      if (i > 0) check("b2b_accept_spacing", acc - prev, 1);
      prev = acc;
    end
    wait_drain();

    // Stage 0 sequence: busy for exactly eight issue cycles.
    start_seq(0, 1'b0, 1'b1);
    busy_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("seq_s0_busy_cycles", busy_cnt, 8);
    wait_drain();

    // seq_start wins over a same-cycle request.
    req_valid = 1'b1;
    req_idx   = LOG_N'(3);
    seq_start = 1'b1;
    seq_stage = STG_W'(1);
    inv       = 1'b1;
    @(negedge clk);
    check("prio_req_ready", int'(req_ready), 0);
    for (int j = 0; j < 8; j++) q_exp.push_back('{k: (j % 4) << 1, inv: 1'b1, last: (j == 7)});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seq_start = 1'b0;
    wait_drain();

    // Stage 2 with a five-cycle stall mid-stream.
    start_seq(2, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("stall_valid_held", int'(out_valid), 1);
      check("stall_req_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Stage 3: all indices fold to k=0.
    start_seq(3, 1'b0, 1'b1);
    wait_drain();

    // seq_start while busy is ignored.
    start_seq(1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("busy_before_restart", int'(busy), 1);
    start_seq(0, 1'b1, 1'b0);
    wait_drain();
    repeat (15) @(posedge clk);
    #1;
    check("no_extra_outputs", q_exp.size(), 0);

    // Reset during RUN aborts the sequence.
    start_seq(0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_w_re", int'(W_re), 0);
    check("midrst_w_im", int'(W_im), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_busy", int'(busy), 0);
    q_exp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("post_rst_idle", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send_req(5, 1'b1, acc);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
